mem_bus_ic: RTL

MEM_BUS_IC -- requirements
Module: mem_bus_ic

---
 rtl/mem_bus_pkg.sv | 29 ++
 rtl/mem_bus_decode.sv | 28 ++
 rtl/mem_bus_ic.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_pkg
// Purpose  : Shared types and constants for the CPU native-bus interconnect:
//            FSM state encoding, slave target encoding, and the address
//            region nibbles (mem_addr[31:28]) used by the decoder.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TGT_RAM  = 2'd0,
        TGT_UART = 2'd1,
        TGT_NONE = 2'd2
    } target_t;

    localparam logic [3:0] c_RGN_RAM_0 = 4'h0;
    localparam logic [3:0] c_RGN_UART  = 4'h5;
    localparam logic [3:0] c_RGN_RAM_8 = 4'h8;
    localparam logic [3:0] c_RGN_RAM_9 = 4'h9;

endpackage
`default_nettype wire

// File: rtl/mem_bus_decode.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_decode
// Purpose  : Combinational region decoder. Maps the top address nibble to a
//            slave target; anything not listed is reported as unmapped.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_decode
    import mem_bus_pkg::*;
(
    input  logic [3:0] i_region,
    output target_t    o_target
);

    // Region nibble to slave lookup
    always_comb begin
        o_target = TGT_NONE;
        case (i_region)
            c_RGN_RAM_0,
            c_RGN_RAM_8,
            c_RGN_RAM_9: o_target = TGT_RAM;
            c_RGN_UART:  o_target = TGT_UART;
            default:     o_target = TGT_NONE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_ic.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_ic
// Purpose  : Single-master native-bus interconnect routing CPU requests to a
//            RAM or UART slave through an IDLE -> ACCESS -> DONE handshake.
//            Unmapped accesses complete with zero data and set sticky bus_err.
//            Optional access timeout enabled by defining MEM_BUS_IC_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_ic
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        ram_valid,
    input  logic        ram_ready,
    input  logic [31:0] ram_rdata,
    output logic        uart_valid,
    input  logic        uart_ready,
    input  logic [31:0] uart_rdata,
    output logic        bus_err
);

    // An empty labelled block that only exists for an illegal parameter value;
    // it also keeps TIMEOUT_CYCLES referenced when the timeout is compiled out.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_cycles_out_of_range
    end

    state_t      r_state;
    state_t      w_state_nxt;
    target_t     r_target;
    target_t     w_dec_target;
    logic        w_accept;
    logic        w_capture;
    logic        w_sel_ready;
    logic [31:0] w_sel_rdata;

    mem_bus_decode u_decode (
        .i_region (mem_addr[31:28]),
        .o_target (w_dec_target)
    );

`ifdef MEM_BUS_IC_TIMEOUT_EN
    localparam logic [16:0] c_TMO_LIMIT = 17'(TIMEOUT_CYCLES);

    logic [15:0] r_tmo_cnt;
    logic        w_tmo_hit;
    logic        w_timeout;

    // The current cycle is the last one allowed before the access is abandoned
    assign w_tmo_hit = (({1'b0, r_tmo_cnt} + 17'd1) == c_TMO_LIMIT);

    // Wait-cycle counter: restarts on every accepted request, counts stalled ACCESS cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= 16'd0;
        end else if (w_accept) begin
            r_tmo_cnt <= 16'd0;
        end else if (r_state == ST_ACCESS && !w_sel_ready) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and state-decoded handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_sel_ready = 1'b0;
        w_sel_rdata = ram_rdata;
        ram_valid   = 1'b0;
        uart_valid  = 1'b0;
        mem_ready   = 1'b0;
`ifdef MEM_BUS_IC_TIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (mem_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_dec_target == TGT_NONE) ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                ram_valid  = (r_target == TGT_RAM);
                uart_valid = (r_target == TGT_UART);
                // Only the latched target's ready/rdata is ever looked at
                if (r_target == TGT_UART) begin
                    w_sel_ready = uart_ready;
                    w_sel_rdata = uart_rdata;
                end else if (r_target == TGT_RAM) begin
                    w_sel_ready = ram_ready;
                    w_sel_rdata = ram_rdata;
                end
                if (w_sel_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
`ifdef MEM_BUS_IC_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                mem_ready   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch, read-data capture and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_addr    <= 32'd0;
            m_wdata   <= 32'd0;
            m_wstrb   <= 4'd0;
            r_target  <= TGT_NONE;
            mem_rdata <= 32'd0;
            bus_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                m_addr   <= mem_addr;
                m_wdata  <= mem_wdata;
                m_wstrb  <= mem_wstrb;
                r_target <= w_dec_target;
                if (w_dec_target == TGT_NONE) begin
                    mem_rdata <= 32'd0;
                    bus_err   <= 1'b1;
                end
            end
            if (w_capture) begin
                mem_rdata <= w_sel_rdata;
            end
`ifdef MEM_BUS_IC_TIMEOUT_EN
            if (w_timeout) begin
                mem_rdata <= 32'd0;
                bus_err   <= 1'b1;
            end
`endif
        end
    end

endmodule
`default_nettype wire
